// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: PicoBlaze port registers plus the timed bus sequencer for a
// multiplexed address/data real-time-clock chip.
// Latency: a command strobe at edge k puts the bus in the address setup phase
//          after edge k. A transaction lasts 2*(1+T_PULSE+T_HOLD)+T_GAP+1 clocks.
// Backpressure: none. A command issued while busy is dropped and sets the sticky
//          err flag, unless the RTC_CMD_QUEUE_EN build holds it in a one-entry queue.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   act_rtc, port_id,   PicoBlaze port side: out_port/write_strobe write the
//   out_port,           registers, read_strobe qualifies the RDATA read, and
//   write_strobe,       in_port_rtc is the registered read-back for the
//   read_strobe,        input mux
//   in_port_rtc
//   rtc_*               chip side: cs_n, ad_sel, wr_n, rd_n, ad_out/ad_oe
//                       (the tri-state is built above) and sampled ad_in
//   busy                a bus transaction is in progress
//
// Register map (port_id[2:0]):
//   write 0 ADDR, write 1 WDATA and issue WRITE, write 2 issue READ,
//   write 3 bit2=1 clears err
//   read  3 STATUS = {5'b0, err, rdv, busy}, read 4 RDATA (clears rdv)
//
// Build option: define RTC_CMD_QUEUE_EN to add the one-entry command queue.
module rtc_bus_ctrl #(
    parameter int T_PULSE = 4,  // clocks each WR_n/RD_n strobe is low (1..256)
    parameter int T_HOLD  = 2,  // clocks after strobe release (1..256)
    parameter int T_GAP   = 2   // clocks between address and data phase (1..256)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       act_rtc,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port_rtc,
    output logic       rtc_cs_n,
    output logic       rtc_ad_sel,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_in,
    output logic       busy
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_A_SETUP = 4'd1;
    localparam logic [3:0] S_A_STRB  = 4'd2;
    localparam logic [3:0] S_A_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP     = 4'd4;
    localparam logic [3:0] S_D_SETUP = 4'd5;
    localparam logic [3:0] S_D_STRB  = 4'd6;
    localparam logic [3:0] S_D_HOLD  = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

    // ------------------------------------------------------------------
    // Port decode
    // ------------------------------------------------------------------
    logic [2:0] reg_sel;
    logic       wr_acc;
    logic       cmd_wr;
    logic       cmd_rd;
    logic       cmd;
    logic [7:0] cmd_wdata;
    logic       rdata_rd;
    logic       err_clr;
    logic       unused_port_bits;

    assign reg_sel   = port_id[2:0];
    assign wr_acc    = act_rtc & write_strobe;
    assign cmd_wr    = wr_acc & (reg_sel == 3'd1);
    assign cmd_rd    = wr_acc & (reg_sel == 3'd2);
    assign cmd       = cmd_wr | cmd_rd;
    assign rdata_rd  = act_rtc & read_strobe & (reg_sel == 3'd4);
    assign err_clr   = wr_acc & (reg_sel == 3'd3) & out_port[2];
    // The upper port_id bits belong to the external port decoder.
    assign unused_port_bits = ^port_id[7:3];

    // Registers the micro sees
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic [7:0] rdata_r;
    logic       rdv;
    logic       err;

    // A WRITE command carries the byte being written to WDATA in the same
    // strobe, so the command must take out_port rather than the old register.
    assign cmd_wdata = cmd_wr ? out_port : wdata_r;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // Shadow of the transaction on the bus; later register writes leave it alone
    logic       sh_rd;
    logic [7:0] sh_addr;
    logic [7:0] sh_wdata;
    logic       sh_rd_nxt;
    logic [7:0] sh_addr_nxt;
    logic [7:0] sh_wdata_nxt;

    logic       cmd_drop;
    logic       rd_sample;

`ifdef RTC_CMD_QUEUE_EN
    logic       q_vld;
    logic       q_rd;
    logic [7:0] q_addr;
    logic [7:0] q_wdata;
    logic       q_push;
    logic       q_pop;

    assign q_push   = cmd & (state != S_IDLE) & ~q_vld;
    assign q_pop    = (state == S_DONE) & q_vld;
    assign cmd_drop = cmd & (state != S_IDLE) & q_vld;
`else
    assign cmd_drop = cmd & (state != S_IDLE);
`endif

    // A read captures the AD bus on the final clock of its data strobe.
    assign rd_sample = (state == S_D_STRB) & (cnt == 8'd0) & sh_rd;

    always_comb begin
        state_nxt    = state;
        sh_rd_nxt    = sh_rd;
        sh_addr_nxt  = sh_addr;
        sh_wdata_nxt = sh_wdata;

        case (state)
            S_IDLE: begin
                if (cmd) begin
                    state_nxt    = S_A_SETUP;
                    sh_rd_nxt    = cmd_rd;
                    sh_addr_nxt  = addr_r;
                    sh_wdata_nxt = cmd_wdata;
                end
            end
            S_A_SETUP: state_nxt = S_A_STRB;
            S_A_STRB:  if (cnt == 8'd0) state_nxt = S_A_HOLD;
            S_A_HOLD:  if (cnt == 8'd0) state_nxt = S_GAP;
            S_GAP:     if (cnt == 8'd0) state_nxt = S_D_SETUP;
            S_D_SETUP: state_nxt = S_D_STRB;
            S_D_STRB:  if (cnt == 8'd0) state_nxt = S_D_HOLD;
            S_D_HOLD:  if (cnt == 8'd0) state_nxt = S_DONE;
            S_DONE: begin
                state_nxt = S_IDLE;
`ifdef RTC_CMD_QUEUE_EN
                // A queued command starts without passing through IDLE.
                if (q_vld) begin
                    state_nxt    = S_A_SETUP;
                    sh_rd_nxt    = q_rd;
                    sh_addr_nxt  = q_addr;
                    sh_wdata_nxt = q_wdata;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every state is entered from a different state, so a state change is
    // exactly the moment to load the dwell count for the new state.
    always_comb begin
        cnt_nxt = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
        if (state_nxt != state) begin
            case (state_nxt)
                S_A_STRB, S_D_STRB: cnt_nxt = LD_PULSE;
                S_A_HOLD, S_D_HOLD: cnt_nxt = LD_HOLD;
                S_GAP:              cnt_nxt = LD_GAP;
                default:            cnt_nxt = 8'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus output decode from the next state so every pin comes straight
    // off a flop and changes in step with the state register.
    // ------------------------------------------------------------------
    logic       cs_n_nxt;
    logic       ad_sel_nxt;
    logic       wr_n_nxt;
    logic       rd_n_nxt;
    logic [7:0] ad_out_nxt;
    logic       ad_oe_nxt;

    always_comb begin
        cs_n_nxt   = 1'b1;
        ad_sel_nxt = 1'b1;
        wr_n_nxt   = 1'b1;
        rd_n_nxt   = 1'b1;
        ad_out_nxt = 8'h00;
        ad_oe_nxt  = 1'b0;
        case (state_nxt)
            S_A_SETUP, S_A_STRB, S_A_HOLD: begin
                cs_n_nxt   = 1'b0;
                ad_sel_nxt = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = sh_addr_nxt;
                // The address latch strobe is WR_n for reads and writes alike.
                wr_n_nxt   = (state_nxt != S_A_STRB);
            end
            S_D_SETUP, S_D_STRB, S_D_HOLD: begin
                cs_n_nxt   = 1'b0;
                ad_sel_nxt = 1'b1;
                if (!sh_rd_nxt) begin
                    ad_oe_nxt  = 1'b1;
                    ad_out_nxt = sh_wdata_nxt;
                end
                if (state_nxt == S_D_STRB) begin
                    wr_n_nxt = sh_rd_nxt;
                    rd_n_nxt = ~sh_rd_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            sh_rd      <= 1'b0;
            sh_addr    <= 8'h00;
            sh_wdata   <= 8'h00;
            rtc_cs_n   <= 1'b1;
            rtc_ad_sel <= 1'b1;
            rtc_wr_n   <= 1'b1;
            rtc_rd_n   <= 1'b1;
            rtc_ad_out <= 8'h00;
            rtc_ad_oe  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sh_rd      <= sh_rd_nxt;
            sh_addr    <= sh_addr_nxt;
            sh_wdata   <= sh_wdata_nxt;
            rtc_cs_n   <= cs_n_nxt;
            rtc_ad_sel <= ad_sel_nxt;
            rtc_wr_n   <= wr_n_nxt;
            rtc_rd_n   <= rd_n_nxt;
            rtc_ad_out <= ad_out_nxt;
            rtc_ad_oe  <= ad_oe_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

`ifdef RTC_CMD_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld   <= 1'b0;
            q_rd    <= 1'b0;
            q_addr  <= 8'h00;
            q_wdata <= 8'h00;
        end else if (q_push) begin
            q_vld   <= 1'b1;
            q_rd    <= cmd_rd;
            q_addr  <= addr_r;
            q_wdata <= cmd_wdata;
        end else if (q_pop) begin
            q_vld   <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Micro-visible registers and read-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r      <= 8'h00;
            wdata_r     <= 8'h00;
            rdata_r     <= 8'h00;
            rdv         <= 1'b0;
            err         <= 1'b0;
            in_port_rtc <= 8'h00;
        end else begin
            if (wr_acc && reg_sel == 3'd0) addr_r  <= out_port;
            if (cmd_wr)                    wdata_r <= out_port;

            if (rd_sample)                 rdata_r <= rtc_ad_in;

            // Fresh data beats a simultaneous RDATA read.
            if (rd_sample)                 rdv <= 1'b1;
            else if (rdata_rd)             rdv <= 1'b0;

            // A drop in the same clock as a clear still leaves err set.
            if (cmd_drop)                  err <= 1'b1;
            else if (err_clr)              err <= 1'b0;

            case (reg_sel)
                3'd3:    in_port_rtc <= {5'b0, err, rdv, busy};
                3'd4:    in_port_rtc <= rdata_r;
                default: in_port_rtc <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench for rtc_bus_ctrl with default timing.
// Commands push the bus cycle they should produce; a bus monitor rebuilds each
// transaction from the pins and pops/compares at its DONE clock.
module tb_rtc_bus_ctrl;

    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int T_GAP   = 2;
    localparam int TXN_LEN = 17;          // 2*(1+4+2)+2+1
    localparam int D_OE_LEN = 1 + T_PULSE + T_HOLD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       act_rtc = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port_rtc;
    logic       rtc_cs_n;
    logic       rtc_ad_sel;
    logic       rtc_wr_n;
    logic       rtc_rd_n;
    logic [7:0] rtc_ad_out;
    logic       rtc_ad_oe;
    logic [7:0] rtc_ad_in = 8'h00;
    logic       busy;

    rtc_bus_ctrl #(.T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .act_rtc      (act_rtc),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port_rtc  (in_port_rtc),
        .rtc_cs_n     (rtc_cs_n),
        .rtc_ad_sel   (rtc_ad_sel),
        .rtc_wr_n     (rtc_wr_n),
        .rtc_rd_n     (rtc_rd_n),
        .rtc_ad_out   (rtc_ad_out),
        .rtc_ad_oe    (rtc_ad_oe),
        .rtc_ad_in    (rtc_ad_in),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    // ------------------------------------------------------------------
    // Bus monitor
    // ------------------------------------------------------------------
    logic       prev_in_a = 1'b0;
    logic       prev_in_d = 1'b0;
    logic       prev_busy = 1'b0;
    logic       active = 1'b0;
    int         tx_len, a_wr, d_wr, d_rd, d_oe, busy_gaps;
    int         bcnt = 0;
    int         ntx = 0;
    logic [7:0] a_addr, d_data;

    always @(posedge clk) begin
        logic in_a, in_d;
        exp_t e;
        #1;
        in_a = !rtc_cs_n && !rtc_ad_sel;
        in_d = !rtc_cs_n && rtc_ad_sel;
        if (reset) begin
            active    = 1'b0;
            prev_in_a = 1'b0;
            prev_in_d = 1'b0;
            prev_busy = 1'b0;
            bcnt      = 0;
            ntx       = 0;
        end else begin
            if (in_a && !prev_in_a) begin
                active = 1'b1;
                tx_len = 0; a_wr = 0; d_wr = 0; d_rd = 0; d_oe = 0; busy_gaps = 0;
                a_addr = 8'h00; d_data = 8'h00;
            end
            if (active) begin
                tx_len++;
                if (!busy) busy_gaps++;
                if (in_a && !rtc_wr_n) begin a_wr++; a_addr = rtc_ad_out; end
                if (in_d) begin
                    if (!rtc_wr_n) begin d_wr++; d_data = rtc_ad_out; end
                    if (!rtc_rd_n) d_rd++;
                    if (rtc_ad_oe) d_oe++;
                end
                if (rtc_cs_n && prev_in_d) begin
                    active = 1'b0;
                    ntx++;
                    chk("tx_len", tx_len, TXN_LEN);
                    chk("tx_busy_gaps", busy_gaps, 0);
                    chk("a_strobe_len", a_wr, T_PULSE);
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_tx", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("tx_addr", a_addr, e.addr);
                        if (e.rd) begin
                            chk("rd_strobe_len", d_rd, T_PULSE);
                            chk("rd_wr_strobe", d_wr, 0);
                            chk("rd_data_oe", d_oe, 0);
                        end else begin
                            chk("wr_strobe_len", d_wr, T_PULSE);
                            chk("wr_rd_strobe", d_rd, 0);
                            chk("wr_data_oe", d_oe, D_OE_LEN);
                            chk("wr_data", d_data, e.data);
                        end
                    end
                end
            end
            if (busy) bcnt++;
            if (!busy && prev_busy) begin
                chk("busy_run_len", bcnt, TXN_LEN * ntx);
                bcnt = 0;
                ntx  = 0;
            end
            prev_in_a = in_a;
            prev_in_d = in_d;
            prev_busy = busy;
        end
    end

    // ------------------------------------------------------------------
    // Port access tasks
    // ------------------------------------------------------------------
    task automatic wr_port(input logic [2:0] id, input logic [7:0] d, input logic act);
        @(negedge clk);
        act_rtc      = act;
        port_id      = {5'b0, id};
        out_port     = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        act_rtc      = 1'b0;
    endtask

    task automatic rd_port(input logic [2:0] id, output logic [7:0] d);
        @(negedge clk);
        act_rtc     = 1'b1;
        port_id     = {5'b0, id};
        read_strobe = 1'b1;
        @(posedge clk);
        #1 d = in_port_rtc;
        @(negedge clk);
        read_strobe = 1'b0;
        act_rtc     = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #2 if (!busy) done = 1;
        end
        if (!done) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        exp_t e;
        int act_cnt;
        bit hit;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_port", in_port_rtc, 8'h00);
        chk("rst_cs_n", rtc_cs_n, 1);
        chk("rst_ad_sel", rtc_ad_sel, 1);
        chk("rst_wr_n", rtc_wr_n, 1);
        chk("rst_rd_n", rtc_rd_n, 1);
        chk("rst_ad_out", rtc_ad_out, 8'h00);
        chk("rst_ad_oe", rtc_ad_oe, 0);
        chk("rst_busy", busy, 0);
        rd_port(3'd3, d);
        chk("rst_status", d, 8'h00);
        rd_port(3'd4, d);
        chk("rst_rdata", d, 8'h00);

        // Write transaction
        wr_port(3'd0, 8'h21, 1'b1);
        e = '{rd: 1'b0, addr: 8'h21, data: 8'h45};
        sb.push_back(e);
        wr_port(3'd1, 8'h45, 1'b1);
        chk("busy_after_cmd", busy, 1);
        wait_idle();

        // Read transaction
        rtc_ad_in = 8'h59;
        wr_port(3'd0, 8'h22, 1'b1);
        e = '{rd: 1'b1, addr: 8'h22, data: 8'h00};
        sb.push_back(e);
        wr_port(3'd2, 8'hff, 1'b1);
        wait_idle();
        rtc_ad_in = 8'h00;
        rd_port(3'd3, d);
        chk("rd_status_rdv", d, 8'h02);
        rd_port(3'd4, d);
        chk("rd_rdata", d, 8'h59);
        rd_port(3'd3, d);
        chk("rd_status_clr", d, 8'h00);

        // Command while busy; WDATA register changes but running shadow stays
        wr_port(3'd0, 8'h30, 1'b1);
        e = '{rd: 1'b0, addr: 8'h30, data: 8'h31};
        sb.push_back(e);
        wr_port(3'd1, 8'h31, 1'b1);
`ifdef RTC_CMD_QUEUE_EN
        e = '{rd: 1'b0, addr: 8'h30, data: 8'h99};
        sb.push_back(e);
        wr_port(3'd1, 8'h99, 1'b1);
        rd_port(3'd3, d);
        chk("busy_status_queued", d, 8'h01);
        wait_idle();
        rd_port(3'd3, d);
        chk("queued_status_idle", d, 8'h00);
`else
        wr_port(3'd1, 8'h99, 1'b1);
        rd_port(3'd3, d);
        chk("busy_status_err", d, 8'h05);
        wait_idle();
        rd_port(3'd3, d);
        chk("err_sticky", d, 8'h04);
        wr_port(3'd3, 8'h04, 1'b1);
        rd_port(3'd3, d);
        chk("err_cleared", d, 8'h00);
`endif

        // Reset during the data strobe of a write
        wr_port(3'd0, 8'h40, 1'b1);
        wr_port(3'd1, 8'h41, 1'b1);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #2 if (!rtc_cs_n && rtc_ad_sel && !rtc_wr_n) hit = 1;
        end
        chk("reached_d_strb", hit, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("abort_cs_n", rtc_cs_n, 1);
        chk("abort_wr_n", rtc_wr_n, 1);
        chk("abort_ad_oe", rtc_ad_oe, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        rd_port(3'd3, d);
        chk("abort_status", d, 8'h00);

        // Command strobe without act_rtc produces no bus activity
        wr_port(3'd1, 8'h77, 1'b0);
        act_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #2 if (!rtc_cs_n || busy || rtc_ad_oe) act_cnt++;
        end
        chk("no_act_activity", act_cnt, 0);

        chk("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus sequencer between the PicoBlaze I/O ports and the external multiplexed address/data real-time-clock chip. The micro writes the RTC register address and data through its output ports. The block then generates the timed RTC bus cycle (CS, A/D select, WR/RD strobes, AD bus drive) and returns read data and status through the RTC input port. It sits behind the port-ID decoder: it is enabled by the RTC select and feeds the RTC leg of the input mux.

## Interface
Parameters:
- T_PULSE, 4: clocks each WR_n/RD_n strobe is held low (≥1).
- T_HOLD, 2: clocks between strobe release and the next phase or the release of CS_n (≥1).
- T_GAP, 2: clocks between the address phase and the data phase (≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- act_rtc  in  1  RTC select from the port-ID decoder.
- port_id  in  8  PicoBlaze port ID; bits [2:0] select the register.
- out_port  in  8  PicoBlaze output data.
- write_strobe  in  1  OUTPUT/OUTPUTK strobe; one clock wide.
- read_strobe  in  1  INPUT strobe; one clock wide.
- in_port_rtc  out  8  registered read-back to the input mux.
- rtc_cs_n  out  1  chip select, active low.
- rtc_ad_sel  out  1  A/D select: 0 = address phase, 1 = data phase.
- rtc_wr_n  out  1  write strobe, active low.
- rtc_rd_n  out  1  read strobe, active low.
- rtc_ad_out  out  8  AD bus drive value.
- rtc_ad_oe  out  1  AD bus output enable; the top level builds the tri-state.
- rtc_ad_in  in  8  AD bus sampled value.
- busy  out  1  a transaction is in progress.

## Operation
Register map. Writes are taken when `act_rtc & write_strobe`:
- 0: ADDR register.
- 1: WDATA register; the write also issues a WRITE command.
- 2: issues a READ command; the data written is ignored.

Reads are selected by port_id[2:0]:
- 3: STATUS = {5'b0, err, rdv, busy}.
- 4: RDATA. Reading RDATA with `read_strobe & act_rtc` clears rdv.

FSM states: IDLE, A_SETUP, A_STRB, A_HOLD, GAP, D_SETUP, D_STRB, D_HOLD, DONE.
- IDLE → A_SETUP on a command. The command latches ADDR/WDATA and the rd/wr type into a shadow.
- A_SETUP, 1 clk: cs_n=0, ad_sel=0, oe=1, ad_out=addr.
- A_STRB, T_PULSE clks: wr_n=0.
- A_HOLD, T_HOLD clks: wr_n=1, address still driven.
- GAP, T_GAP clks: oe=0, cs_n=1.
- D_SETUP, 1 clk: cs_n=0, ad_sel=1. For a write, oe=1 and ad_out=wdata. For a read, oe=0.
- D_STRB, T_PULSE clks: wr_n=0 for a write or rd_n=0 for a read. A read samples rtc_ad_in into RDATA on the last D_STRB clock and sets rdv.
- D_HOLD, T_HOLD clks: strobes are high; a write keeps driving the data.
- DONE, 1 clk: cs_n=1, oe=0. Go to IDLE, or to A_SETUP if a command is queued.

General rules:
- A single down-counter loads (N−1) on state entry. The state advances when the count is 0.
- busy=1 in every state except IDLE.
- Writing ADDR or WDATA while busy updates only the registers; the shadow used by the running transaction is unchanged.
- Without RTC_CMD_QUEUE_EN, a command issued while busy is dropped and err is set. err is sticky and is cleared by reset or by writing port 3 with bit2=1.
- On simultaneous rdv set (end of D_STRB) and RDATA read: the new data wins and rdv=1.
- A reset in any state returns the block to IDLE on the next edge. Bus idle levels are restored at the same edge.

## Timing
- Reset values: in_port_rtc=0, rtc_cs_n=1, rtc_ad_sel=1, rtc_wr_n=1, rtc_rd_n=1, rtc_ad_out=0, rtc_ad_oe=0, busy=0. ADDR, WDATA, RDATA, rdv and err are 0.
- A command strobe at edge k gives busy=1 and state A_SETUP after edge k.
- Total transaction length is 2·(1+T_PULSE+T_HOLD)+T_GAP+1 clocks. With the default parameters this is 17.
- in_port_rtc is registered from port_id[2:0] every clock, so it is valid one clock after port_id. This matches the KCPSM6 two-cycle INPUT.
- All bus outputs are registered and glitch-free.

## Configuration
- RTC_CMD_QUEUE_EN defined:
  - A one-entry queue holds {type, addr, wdata} for a command issued while busy.
  - DONE then goes directly to A_SETUP.
  - A second command while the queue is full is dropped and sets err.
- RTC_CMD_QUEUE_EN undefined:
  - There is no queue; any command while busy is dropped and sets err.

## Test plan
- Reset, then idle: all outputs are at their reset values and STATUS reads 0x00.
- Write ADDR=0x21, then write WDATA=0x45:
  - address phase shows ad_out=0x21 with wr_n low for exactly 4 clocks;
  - data phase shows ad_sel=1, ad_out=0x45 and wr_n low for 4 clocks;
  - busy is high for 17 clocks.
- Write ADDR=0x22, issue READ with rtc_ad_in=0x59 during D_STRB:
  - rd_n is low for 4 clocks and oe=0 during the data phase;
  - STATUS reads 0x02, then RDATA reads 0x59;
  - STATUS afterwards reads 0x00.
- WRITE command issued while busy:
  - queue build: the second transaction starts directly after DONE, with no extra IDLE clock;
  - no-queue build: the command is dropped and STATUS=0x05; writing 0x04 to port 3 clears err.
- Assert reset during D_STRB of a write: the next edge gives cs_n=1, wr_n=1, oe=0 and busy=0, and no rdv is set.
- Commands with act_rtc=0 (port 1 written while another peripheral is decoded): no bus activity occurs.
